// File: rtl/falling_item_if.sv
// Control and status bundle between the item array and its player/render/score clients.
// The array owns the slave side; the controlling logic (or bench) owns the master side.
interface falling_item_if #(
   parameter int NUM_ITEMS = 4
);
   logic                      pause;
   logic [1:0]                speed;
   logic                      catch_valid;
   logic [2:0]                catch_idx;
   logic                      catch_ack;
   logic [NUM_ITEMS-1:0]      active;
   logic [10*NUM_ITEMS-1:0]   pos_x;
   logic [10*NUM_ITEMS-1:0]   pos_y;
   logic [2*NUM_ITEMS-1:0]    color;
   logic                      caught;
   logic                      missed;
   logic [7:0]                miss_count;

   modport master (
      output pause, speed, catch_valid, catch_idx,
      input  catch_ack, active, pos_x, pos_y, color, caught, missed, miss_count
   );

   modport slave (
      input  pause, speed, catch_valid, catch_idx,
      output catch_ack, active, pos_x, pos_y, color, caught, missed, miss_count
   );
endinterface

// File: rtl/falling_item_array.sv
// Multi-slot falling-item generator: LFSR-driven spawns, per-tick fall, catch/miss retirement.
// All state moves on the fall tick; outputs are registered.
module falling_item_array #(
   parameter int          NUM_ITEMS = 4,
   parameter int          X_MAX     = 620,
   parameter int          Y_FLOOR   = 400,
   parameter int          STEP_BASE = 15,
   parameter int          STEP_INC  = 5,
   parameter int          SPAWN_GAP = 6,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic            fall_clk,
   input  logic            rst,
   falling_item_if.slave   bus
);
   localparam int              SCW        = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam logic [SCW-1:0]  GAP_RELOAD = SCW'(SPAWN_GAP - 1);
   localparam logic [15:0]     LFSR_MASK  = 16'hB400;

   logic [15:0]                     lfsr;
   logic [1:0]                      cnt;
   logic [SCW-1:0]                  spawn_cnt;
   logic [NUM_ITEMS-1:0]            active;
   logic [NUM_ITEMS-1:0][9:0]       x_q;
   logic [NUM_ITEMS-1:0][9:0]       y_q;
   logic [NUM_ITEMS-1:0][1:0]       c_q;
   logic                            catch_ack_q;
   logic                            caught_q;
   logic                            missed_q;
   logic [7:0]                      miss_cnt_q;

   logic [10:0]                     step;
   logic [NUM_ITEMS-1:0][10:0]      ny;
   logic [NUM_ITEMS-1:0]            catch_sel;
   logic [NUM_ITEMS-1:0]            floor_sel;
   logic [NUM_ITEMS-1:0]            spawn_sel;
   logic                            any_idle;
   logic                            spawn_go;
   logic [9:0]                      rnd;
   logic [9:0]                      spawn_x;
   logic [1:0]                      spawn_c;
   logic [15:0]                     lfsr_next;

   assign step      = 11'(STEP_BASE) + 11'(bus.speed) * 11'(STEP_INC);
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
   assign rnd       = lfsr[9:0];
   // Single conditional subtract is enough because X_MAX >= 512 folds all of 0..1023 into range.
   assign spawn_x   = (rnd < 10'(X_MAX)) ? rnd : rnd - 10'(X_MAX);
   assign spawn_c   = (lfsr[11:10] != 2'b00) ? lfsr[11:10] : cnt;
   assign spawn_go  = (spawn_cnt == '0) && any_idle;

   always_comb begin
      ny        = '0;
      catch_sel = '0;
      floor_sel = '0;
      spawn_sel = '0;
      any_idle  = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         ny[i]        = {1'b0, y_q[i]} + step;
         catch_sel[i] = bus.catch_valid && (bus.catch_idx == 3'(i)) && active[i];
         // A catch on the same slot pre-empts the floor check.
         floor_sel[i] = active[i] && !catch_sel[i] && (ny[i] >= 11'(Y_FLOOR));
         if (!active[i] && !any_idle) begin
            spawn_sel[i] = 1'b1;
            any_idle     = 1'b1;
         end
      end
   end

   always_ff @(posedge fall_clk or posedge rst) begin
      if (rst) begin
         lfsr        <= SEED;
         cnt         <= 2'd1;
         spawn_cnt   <= '0;
         active      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         c_q         <= '0;
         catch_ack_q <= 1'b0;
         caught_q    <= 1'b0;
         missed_q    <= 1'b0;
         miss_cnt_q  <= '0;
      end else begin
         lfsr        <= lfsr_next;
         catch_ack_q <= 1'b0;
         caught_q    <= 1'b0;
         missed_q    <= 1'b0;
         if (!bus.pause) begin
            catch_ack_q <= |catch_sel;
            caught_q    <= |catch_sel;
            missed_q    <= |floor_sel;
            if (|floor_sel && miss_cnt_q != 8'hFF)
               miss_cnt_q <= miss_cnt_q + 8'd1;
            if (spawn_cnt != '0)
               spawn_cnt <= spawn_cnt - 1'b1;
            else if (spawn_go) begin
               spawn_cnt <= GAP_RELOAD;
               if (lfsr[11:10] == 2'b00)
                  cnt <= (cnt == 2'd3) ? 2'd1 : cnt + 2'd1;
            end
            // Eligibility uses the start-of-tick active vector, so a slot retired now waits a tick.
            for (int i = 0; i < NUM_ITEMS; i++) begin
               if (catch_sel[i] || floor_sel[i])
                  active[i] <= 1'b0;
               else if (active[i])
                  y_q[i] <= ny[i][9:0];
               else if (spawn_go && spawn_sel[i]) begin
                  active[i] <= 1'b1;
                  x_q[i]    <= spawn_x;
                  y_q[i]    <= '0;
                  c_q[i]    <= spawn_c;
               end
            end
         end
      end
   end

   assign bus.catch_ack  = catch_ack_q;
   assign bus.caught     = caught_q;
   assign bus.missed     = missed_q;
   assign bus.miss_count = miss_cnt_q;
   assign bus.active     = active;
   assign bus.pos_x      = x_q;
   assign bus.pos_y      = y_q;
   assign bus.color      = c_q;
endmodule

// File: tb/tb_falling_item_array.sv
// Directed bench for falling_item_array: fall/miss tables, catch and pause sequences,
// spawn x/colour checks against an LFSR reference, and miss-count saturation.
module tb_falling_item_array;
   localparam logic [15:0] SEED = 16'hACE1;

   logic fall_clk;
   logic rst;

   falling_item_if #(.NUM_ITEMS(4)) bus();

   falling_item_array #(.NUM_ITEMS(4)) dut (
      .fall_clk (fall_clk),
      .rst      (rst),
      .bus      (bus.slave)
   );

   initial fall_clk = 1'b0;
   always #5 fall_clk = ~fall_clk;

   typedef struct {
      int         seq;
      int         e;
      logic [3:0] act;
      logic [9:0] y0;
      logic [9:0] y1;
      logic       missed;
      logic [7:0] mc;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [NV];

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [15:0] m_lfsr, m_prev;
   logic [1:0]  m_cnt;
   logic [3:0]  prev_act;
   int          m_miss;

   // Reference LFSR: value used at the most recent edge is m_prev.
   always @(posedge fall_clk or posedge rst) begin
      if (rst) begin
         m_lfsr <= SEED;
         m_prev <= SEED;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_active"}, 32'(bus.active), 0);
      chk({tag, "_pos_x"}, 32'(bus.pos_x), 0);
      chk({tag, "_pos_y"}, 32'(bus.pos_y), 0);
      chk({tag, "_color"}, 32'(bus.color), 0);
      chk({tag, "_pulses"}, {29'd0, bus.catch_ack, bus.caught, bus.missed}, 0);
      chk({tag, "_miss_count"}, 32'(bus.miss_count), 0);
   endtask

   task automatic check_spawn();
      logic [3:0] nb;
      logic [9:0] r, ex;
      logic [1:0] ec;
      nb = bus.active & ~prev_act;
      for (int i = 0; i < 4; i++) begin
         if (nb[i]) begin
            r  = m_prev[9:0];
            ex = (r < 10'd620) ? r : r - 10'd620;
            ec = (m_prev[11:10] != 2'b00) ? m_prev[11:10] : m_cnt;
            if (m_prev[11:10] == 2'b00)
               m_cnt = (m_cnt == 2'd3) ? 2'd1 : m_cnt + 2'd1;
            chk("spawn_x", 32'(bus.pos_x[10*i +: 10]), 32'(ex));
            chk("spawn_color", 32'(bus.color[2*i +: 2]), 32'(ec));
            chk("spawn_y", 32'(bus.pos_y[10*i +: 10]), 0);
         end
      end
      prev_act = bus.active;
   endtask

   task automatic tick();
      @(posedge fall_clk);
      #1;
      check_spawn();
   endtask

   task automatic do_reset();
      bus.pause       = 1'b0;
      bus.speed       = 2'd0;
      bus.catch_valid = 1'b0;
      bus.catch_idx   = 3'd0;
      rst = 1'b1;
      #2;
      @(negedge fall_clk);
      rst      = 1'b0;
      prev_act = 4'b0;
      m_cnt    = 2'd1;
   endtask

   task automatic run_seq(input int sid, input logic [1:0] spd, input int last_e);
      do_reset();
      bus.speed = spd;
      for (int e = 1; e <= last_e; e++) begin
         tick();
         for (int k = 0; k < NV; k++) begin
            if (tbl[k].seq == sid && tbl[k].e == e) begin
               chk("tbl_active", 32'(bus.active), 32'(tbl[k].act));
               chk("tbl_y0", 32'(bus.pos_y[9:0]), 32'(tbl[k].y0));
               chk("tbl_y1", 32'(bus.pos_y[19:10]), 32'(tbl[k].y1));
               chk("tbl_missed", 32'(bus.missed), 32'(tbl[k].missed));
               chk("tbl_miss_count", 32'(bus.miss_count), 32'(tbl[k].mc));
            end
         end
      end
   endtask

   initial begin
      // seq 0: speed 0, step 15; seq 1: speed 3, step 30
      tbl[0]  = '{0,  1, 4'b0001, 10'd0,   10'd0,   1'b0, 8'd0};
      tbl[1]  = '{0,  6, 4'b0001, 10'd75,  10'd0,   1'b0, 8'd0};
      tbl[2]  = '{0,  7, 4'b0011, 10'd90,  10'd0,   1'b0, 8'd0};
      tbl[3]  = '{0, 13, 4'b0111, 10'd180, 10'd90,  1'b0, 8'd0};
      tbl[4]  = '{0, 19, 4'b1111, 10'd270, 10'd180, 1'b0, 8'd0};
      tbl[5]  = '{0, 27, 4'b1111, 10'd390, 10'd300, 1'b0, 8'd0};
      tbl[6]  = '{0, 28, 4'b1110, 10'd390, 10'd315, 1'b1, 8'd1};
      tbl[7]  = '{0, 29, 4'b1111, 10'd0,   10'd330, 1'b0, 8'd1};
      tbl[8]  = '{1,  1, 4'b0001, 10'd0,   10'd0,   1'b0, 8'd0};
      tbl[9]  = '{1,  7, 4'b0011, 10'd180, 10'd0,   1'b0, 8'd0};
      tbl[10] = '{1, 13, 4'b0111, 10'd360, 10'd180, 1'b0, 8'd0};
      tbl[11] = '{1, 14, 4'b0111, 10'd390, 10'd210, 1'b0, 8'd0};
      tbl[12] = '{1, 15, 4'b0110, 10'd390, 10'd240, 1'b1, 8'd1};

      rst = 1'b0;
      bus.pause = 1'b0; bus.speed = 2'd0; bus.catch_valid = 1'b0; bus.catch_idx = 3'd0;
      #1;
      rst = 1'b1;
      #2;
      chk_zero("reset");

      run_seq(0, 2'd0, 29);
      run_seq(1, 2'd3, 15);

      // Catch sequence, speed 0
      do_reset();
      tick();
      bus.catch_valid = 1'b1; bus.catch_idx = 3'd2;
      tick();
      chk("idle_catch_ack", 32'(bus.catch_ack), 0);
      chk("idle_catch_active", 32'(bus.active), 32'b0001);
      chk("idle_catch_y0", 32'(bus.pos_y[9:0]), 15);
      bus.catch_idx = 3'd5;
      tick();
      chk("range_catch_ack", 32'(bus.catch_ack), 0);
      chk("range_catch_y0", 32'(bus.pos_y[9:0]), 30);
      bus.catch_valid = 1'b0;
      for (int e = 4; e <= 27; e++) tick();
      chk("pre_floor_y0", 32'(bus.pos_y[9:0]), 390);
      bus.catch_valid = 1'b1; bus.catch_idx = 3'd0;
      tick();
      chk("floor_catch_ack", 32'(bus.catch_ack), 1);
      chk("floor_catch_caught", 32'(bus.caught), 1);
      chk("floor_catch_missed", 32'(bus.missed), 0);
      chk("floor_catch_mc", 32'(bus.miss_count), 0);
      chk("floor_catch_active", 32'(bus.active), 32'b1110);
      chk("floor_catch_y0", 32'(bus.pos_y[9:0]), 390);
      bus.catch_valid = 1'b0;
      tick();
      chk("respawn_active", 32'(bus.active), 32'b1111);
      chk("respawn_pulses", {30'd0, bus.catch_ack, bus.caught}, 0);
      tick();
      chk("pre_pause_y0", 32'(bus.pos_y[9:0]), 15);
      bus.pause = 1'b1; bus.catch_valid = 1'b1; bus.catch_idx = 3'd0;
      for (int e = 31; e <= 33; e++) begin
         tick();
         chk("pause_ack", 32'(bus.catch_ack), 0);
         chk("pause_y0", 32'(bus.pos_y[9:0]), 15);
         chk("pause_active", 32'(bus.active), 32'b1111);
      end
      bus.pause = 1'b0; bus.catch_valid = 1'b0;
      tick();
      chk("resume_y0", 32'(bus.pos_y[9:0]), 30);
      chk("resume_y1", 32'(bus.pos_y[19:10]), 360);
      tick();
      tick();
      tick();
      chk("late_miss_active", 32'(bus.active), 32'b1101);
      chk("late_miss_missed", 32'(bus.missed), 1);
      chk("late_miss_mc", 32'(bus.miss_count), 1);
      tick();
      chk("late_respawn_active", 32'(bus.active), 32'b1111);
      chk("late_respawn_missed", 32'(bus.missed), 0);
      #3;
      rst = 1'b1;
      #1;
      chk_zero("midfall_reset");

      // Long run at speed 3: miss-count saturation plus spawn colour rotation
      do_reset();
      bus.speed = 2'd3;
      m_miss = 0;
      for (int t = 0; t < 2400; t++) begin
         tick();
         if (bus.missed) m_miss++;
         chk("miss_count_track", 32'(bus.miss_count), (m_miss > 255) ? 255 : m_miss);
      end
      chk("miss_count_saturated", 32'(bus.miss_count), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/falling_item_array.md
Name: falling_item_array

Overview:
- Next-generation falling-object generator: manages NUM_ITEMS independent falling items instead of one.
- Each item slot spawns at a pseudo-random x with a pseudo-random non-zero colour, then falls at a selectable speed.
- A slot retires when it is caught (collision handshake from the player/collision logic) or when it reaches the floor.
- Sits between the fall-tick divider and the VGA renderer / score logic.

Parameters:
- NUM_ITEMS, 4, number of item slots (1..8).
- X_MAX, 620, exclusive upper bound of spawn x; must satisfy 512 <= X_MAX <= 1023.
- Y_FLOOR, 400, y at or beyond which a falling item is missed.
- STEP_BASE, 15, pixels per tick at speed level 0.
- STEP_INC, 5, extra pixels per tick per speed level.
- SPAWN_GAP, 6, ticks between successive spawn attempts.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- fall_clk  in  1  fall tick clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pause  in  1  when 1: freeze positions, the spawn counter, and catch handling.
- speed  in  2  speed level L; step = STEP_BASE + L*STEP_INC.
- catch_valid  in  1  request to retire slot catch_idx as caught.
- catch_idx  in  3  slot index of the catch request.
- catch_ack  out  1  1-tick pulse: catch accepted.
- active  out  NUM_ITEMS  bit i = 1 while slot i is falling.
- pos_x  out  10*NUM_ITEMS  slot i occupies bits [10i+9:10i].
- pos_y  out  10*NUM_ITEMS  slot i occupies bits [10i+9:10i].
- color  out  2*NUM_ITEMS  slot i occupies bits [2i+1:2i]; always 1..3 while active.
- caught  out  1  1-tick pulse when a catch retires a slot.
- missed  out  1  1-tick pulse when any slot hits the floor.
- miss_count  out  8  saturating count of misses.

Behaviour:
- Reset (asynchronous):
  - active = 0; all pos_x, pos_y and color = 0.
  - catch_ack, caught, missed = 0; miss_count = 0.
  - lfsr = SEED; colour rotator cnt = 1; spawn_cnt = 0.
- LFSR:
  - 16-bit Galois LFSR, taps 16,14,13,11 (mask 16'hB400).
  - Advances on every fall_clk edge not in reset, including while paused.
- Per-slot states: IDLE (active=0) and FALLING (active=1).
- Pause: when pause=1, nothing changes except the LFSR. Pulses are 0 and catch requests are ignored (no ack).
- Catch (pause=0):
  - Accepted if catch_valid=1, catch_idx < NUM_ITEMS, and that slot is active.
  - Accepted catch: slot -> IDLE; catch_ack=1 and caught=1 on this edge's outputs; pos/color hold last values.
  - Otherwise: catch_ack=0, with no other effect.
- Fall, for each active slot not being caught this tick:
  - Compute ny = y + step, using 11-bit arithmetic.
  - If ny >= Y_FLOOR: slot -> IDLE, missed=1, miss_count += 1 (saturates at 255). Multiple simultaneous misses count as 1.
  - Else: y = ny.
- Catch vs floor on the same slot in the same tick: the catch wins; no miss is recorded.
- Spawn (pause=0):
  - If spawn_cnt != 0, decrement it.
  - Else, if any slot is IDLE at the start of the tick:
    - The lowest-index IDLE slot -> FALLING with y=0.
    - x = r if r < X_MAX, else r - X_MAX, where r = lfsr[9:0].
    - color = lfsr[11:10], or cnt if that is 00; cnt then rotates 1->2->3->1.
    - spawn_cnt = SPAWN_GAP - 1.
  - Else (all slots busy): spawn_cnt stays 0, so a spawn fires on the first tick a slot is free at tick start.
  - A slot retired this tick is not eligible for respawn until the next tick.
- Latency: spawn, move, catch and miss all take effect on the same edge that evaluates them. Outputs are registered.
- speed is sampled every tick, so a change affects the next step immediately.

Test Plan:
- Reset, pause=0, speed=0, SEED=16'hACE1 -> first edge: slot0 active, y=0, x<620, color!=0. Slot1 spawns 6 ticks later.
- Single slot, speed=0 -> y sequence 0,15,...,390; next tick 405>=400 gives IDLE, missed=1, miss_count=1.
- speed=3 -> step 30; y 0,30,...,390; next tick IDLE with miss.
- catch_valid, idx=0 on the tick slot0 would reach the floor -> caught=1, catch_ack=1, missed=0, miss_count unchanged.
- catch_valid, idx=2 while slot2 is idle, or idx=5 with NUM_ITEMS=4 -> catch_ack=0, no state change. With pause=1 and slot0 active, catch idx=0 -> no ack, y frozen; on release, falling resumes from the same y.
- 300 forced misses -> miss_count saturates at 255. Force lfsr[11:10]=00 on three spawns -> colours 1,2,3. Assert rst mid-fall -> all outputs 0 immediately.
